mode1_max_acc: RTL

MODE1_MAX_ACC -- requirements
Module: mode1_max_acc

---
 rtl/mode1_max_acc.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mode1_max_acc.sv
// Streaming FP16 vector-maximum accumulator: a pairwise max stage feeds a running
// maximum with a saturating beat count, handed off through a valid/ready result port.
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif
`ifndef EXPONENT
`define EXPONENT 5
`endif
`ifndef MANTISSA
`define MANTISSA 10
`endif

module mode1_max_acc #(
  parameter int COUNT_W = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [`DATAWIDTH-1:0] inp0,
  input  logic [`DATAWIDTH-1:0] inp1,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [`DATAWIDTH-1:0] max_out,
  output logic [COUNT_W-1:0]    beat_cnt,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int DW = `DATAWIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  // Maps a sign-magnitude value onto an unsigned key with the same ordering;
  // both zeros collapse to +0 so they compare equal.
  function automatic logic [DW-1:0] order_key(input logic [DW-1:0] v);
    logic [DW-1:0] n;
    n = (v[DW-2:0] == '0) ? '0 : v;
    return n[DW-1] ? ~n : (n | {1'b1, {(DW-1){1'b0}}});
  endfunction

  function automatic logic greater(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return order_key(a) > order_key(b);
  endfunction

  logic          accept;
  logic [DW-1:0] pair_max;
  logic          s1_valid, s1_last, s1_first;

  assign accept = in_valid && in_ready;

  // Stage 1: pairwise max, tie keeps inp0; s1_first marks the opening beat of a vector.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pair_max <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_first <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        pair_max <= greater(inp1, inp0) ? inp1 : inp0;
        s1_last  <= in_last;
        s1_first <= (state == IDLE);
      end
    end
  end

  // Stage 2: running maximum, replaced only on a strictly greater pair.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      max_out  <= '0;
      beat_cnt <= '0;
    end else if (s1_valid) begin
      if (s1_first) begin
        max_out  <= pair_max;
        beat_cnt <= COUNT_W'(1);
      end else begin
        if (greater(pair_max, max_out)) max_out <= pair_max;
        if (beat_cnt != '1) beat_cnt <= beat_cnt + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE, ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) state_next = in_last ? DRAIN : ACCUM;
      end
      DRAIN: state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // s1_last is carried for downstream visibility; the FSM already tracks the drain.
  logic unused_ok;
  assign unused_ok = s1_last;

endmodule
